// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage elastic pipeline register (valid/ready, stall, flush).
// Define PIPE_REG_CHAIN_CLEAR_DATA_EN to clear data registers to RESET_VALUE on reset/flush.
module pipe_reg_chain #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            rdy;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            r      = !valid_q[k] || r;
            rdy[k] = r;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
`ifdef PIPE_REG_CHAIN_CLEAR_DATA_EN
            data_d  = {DEPTH{RESET_VALUE}};
`endif
        end else begin
            if (rdy[0]) begin
                valid_d[0] = in_valid;
                data_d[0]  = in_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    valid_d[k] = valid_q[k-1];
                    data_d[k]  = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) valid_q <= '0;
        else        valid_q <= valid_d;
    end

`ifdef PIPE_REG_CHAIN_CLEAR_DATA_EN
    always_ff @(posedge clk) begin
        if (!reset) data_q <= {DEPTH{RESET_VALUE}};
        else        data_q <= data_d;
    end
`else
    // Data flops are reset-free; only the valid bits carry state that matters.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    logic [WIDTH-1:0] unused_reset_value;
    assign unused_reset_value = RESET_VALUE;
`endif

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

    assign in_ready  = rdy[0] && reset && !flush;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed reset/stream/back-pressure/flush/bubble steps,
// then random valid/ready/flush traffic on WIDTH=32 DEPTH=1 and DEPTH=5 against a queue model.
module tb_pipe_reg_chain;
    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2, WIDTH=8 (directed)
    logic       s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0] s_in_data, s_out_data;
    logic [1:0] s_occ;
    // DEPTH=3, WIDTH=8 (bubble collapse)
    logic       t_flush, t_in_valid, t_in_ready, t_out_valid, t_out_ready;
    logic [7:0] t_in_data, t_out_data;
    logic [1:0] t_occ;
    // WIDTH=32, DEPTH=1 and DEPTH=5 share random inputs
    logic        r_flush, r_in_valid, r_out_ready;
    logic [31:0] r_in_data;
    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [31:0] a_out_data, b_out_data;
    logic [0:0]  a_occ;
    logic [2:0]  b_occ;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(s_out_ready), .occupancy(s_occ));
    pipe_reg_chain #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(rst_n), .flush(t_flush), .in_valid(t_in_valid), .in_data(t_in_data),
        .in_ready(t_in_ready), .out_valid(t_out_valid), .out_data(t_out_data),
        .out_ready(t_out_ready), .occupancy(t_occ));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(rst_n), .flush(r_flush), .in_valid(r_in_valid), .in_data(r_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ready(r_out_ready), .occupancy(a_occ));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(5)) u_d5 (
        .clk(clk), .reset(rst_n), .flush(r_flush), .in_valid(r_in_valid), .in_data(r_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(r_out_ready), .occupancy(b_occ));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[2][$];
    int          dep, n;
    logic        ir, ov, exp_ir;
    logic [31:0] od, oc;
    int          st_occ[5] = '{1, 2, 2, 1, 0};
    int          st_ov[5]  = '{0, 1, 1, 1, 0};

    initial begin
        rst_n = 1'b0;
        s_flush = 0; s_in_valid = 1; s_in_data = 8'h30; s_out_ready = 1;
        t_flush = 0; t_in_valid = 0; t_in_data = 8'h00; t_out_ready = 0;
        r_flush = 0; r_in_valid = 0; r_in_data = 32'h0; r_out_ready = 0;

        // reset held for 3 edges with input offered
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out_valid", 32'(s_out_valid), 32'd0);
            chk("rst_occ", 32'(s_occ), 32'd0);
            chk("rst_in_ready", 32'(s_in_ready), 32'd0);
`ifdef PIPE_REG_CHAIN_CLEAR_DATA_EN
            chk("rst_out_data", 32'(s_out_data), 32'h00);
`endif
        end
        rst_n = 1'b1;
        s_in_valid = 0;
        #1;
        chk("rst_release_in_ready", 32'(s_in_ready), 32'd1);

        // streaming: 0F,10,11 back to back
        for (int i = 0; i < 5; i++) begin
            s_in_valid = (i < 3);
            s_in_data  = 8'(8'h0F + i);
            #1;
            if (i < 3) chk("str_in_ready", 32'(s_in_ready), 32'd1);
            tick();
            chk("str_out_valid", 32'(s_out_valid), 32'(st_ov[i]));
            chk("str_occ", 32'(s_occ), 32'(st_occ[i]));
            if (st_ov[i] == 1) chk("str_out_data", 32'(s_out_data), 32'(8'h0F + i - 1));
        end

        // back-pressure: A1,A2 fill, A3 waits
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 8'hA1; #1;
        chk("bp_ir_a1", 32'(s_in_ready), 32'd1);
        tick();
        chk("bp_occ1", 32'(s_occ), 32'd1);
        s_in_data = 8'hA2; #1;
        chk("bp_ir_a2", 32'(s_in_ready), 32'd1);
        tick();
        chk("bp_occ2", 32'(s_occ), 32'd2);
        chk("bp_data_a1", 32'(s_out_data), 32'hA1);
        s_in_data = 8'hA3; #1;
        chk("bp_ir_full", 32'(s_in_ready), 32'd0);
        tick();
        chk("bp_hold_occ", 32'(s_occ), 32'd2);
        chk("bp_hold_data", 32'(s_out_data), 32'hA1);
        chk("bp_hold_ov", 32'(s_out_valid), 32'd1);
        s_out_ready = 1; #1;
        chk("bp_ir_release", 32'(s_in_ready), 32'd1);
        tick();
        chk("bp_data_a2", 32'(s_out_data), 32'hA2);
        chk("bp_full_thru_occ", 32'(s_occ), 32'd2);
        s_in_valid = 0;
        tick();
        chk("bp_data_a3", 32'(s_out_data), 32'hA3);
        chk("bp_occ_drain", 32'(s_occ), 32'd1);
        tick();
        chk("bp_empty_ov", 32'(s_out_valid), 32'd0);
        chk("bp_empty_occ", 32'(s_occ), 32'd0);

        // flush with occupancy 2 and EE offered
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 8'hB1; tick();
        s_in_data = 8'hB2; tick();
        chk("fl_pre_occ", 32'(s_occ), 32'd2);
        s_flush = 1; s_in_data = 8'hEE; s_out_ready = 1; #1;
        chk("fl_in_ready", 32'(s_in_ready), 32'd0);
        tick();
        s_flush = 0; s_in_valid = 0;
        chk("fl_out_valid", 32'(s_out_valid), 32'd0);
        chk("fl_occ", 32'(s_occ), 32'd0);
`ifdef PIPE_REG_CHAIN_CLEAR_DATA_EN
        chk("fl_out_data", 32'(s_out_data), 32'h00);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_ee", 32'(s_out_valid), 32'd0);
        end

        // bubble collapse on DEPTH=3 with output stalled
        t_in_valid = 1; t_in_data = 8'h55; #1;
        chk("bub_ir0", 32'(t_in_ready), 32'd1);
        tick();
        chk("bub_occ0", 32'(t_occ), 32'd1);
        t_in_valid = 0; #1;
        chk("bub_ir_idle", 32'(t_in_ready), 32'd1);
        tick();
        t_in_valid = 1; t_in_data = 8'h56; #1;
        chk("bub_ir1", 32'(t_in_ready), 32'd1);
        tick();
        chk("bub_occ1", 32'(t_occ), 32'd2);
        chk("bub_ov", 32'(t_out_valid), 32'd1);
        chk("bub_data55", 32'(t_out_data), 32'h55);
        t_in_data = 8'h57; #1;
        chk("bub_ir2", 32'(t_in_ready), 32'd1);
        tick();
        chk("bub_occ_full", 32'(t_occ), 32'd3);
        t_in_data = 8'h58; #1;
        chk("bub_ir_full", 32'(t_in_ready), 32'd0);
        tick();
        chk("bub_hold55", 32'(t_out_data), 32'h55);
        t_out_ready = 1; #1;
        chk("bub_ir_rel", 32'(t_in_ready), 32'd1);
        tick();
        chk("bub_d56", 32'(t_out_data), 32'h56);
        chk("bub_occ_thru", 32'(t_occ), 32'd3);
        t_in_valid = 0;
        tick();
        chk("bub_d57", 32'(t_out_data), 32'h57);
        tick();
        chk("bub_d58", 32'(t_out_data), 32'h58);
        tick();
        chk("bub_empty", 32'(t_out_valid), 32'd0);

        // random traffic on DEPTH=1 and DEPTH=5; last cycles drain
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc < 580) begin
                r_in_valid  = ($urandom_range(3) != 0);
                r_out_ready = ($urandom_range(2) != 0);
                r_flush     = ($urandom_range(39) == 0);
            end else begin
                r_in_valid = 0; r_out_ready = 1; r_flush = 0;
            end
            r_in_data = $urandom;
            #1;
            for (int j = 0; j < 2; j++) begin
                dep = (j == 0) ? 1 : 5;
                ir  = (j == 0) ? a_in_ready  : b_in_ready;
                ov  = (j == 0) ? a_out_valid : b_out_valid;
                od  = (j == 0) ? a_out_data  : b_out_data;
                oc  = (j == 0) ? 32'(a_occ)  : 32'(b_occ);
                n   = q[j].size();
                exp_ir = !r_flush && (n < dep || r_out_ready);
                chk("rnd_in_ready", 32'(ir), 32'(exp_ir));
                chk("rnd_occ", oc, 32'(n));
                chk("rnd_occ_bound", 32'(oc <= 32'(dep)), 32'd1);
                if (n == 0)   chk("rnd_empty_ov", 32'(ov), 32'd0);
                if (n == dep) chk("rnd_full_ov", 32'(ov), 32'd1);
                if (ov && r_out_ready && n > 0) chk("rnd_data", od, q[j][0]);
                if (r_flush) q[j].delete();
                else begin
                    if (ov && r_out_ready && n > 0) void'(q[j].pop_front());
                    if (r_in_valid && exp_ir) q[j].push_back(r_in_data);
                end
            end
            tick();
        end
        chk("rnd_d1_drained", 32'(a_occ), 32'd0);
        chk("rnd_d5_drained", 32'(b_occ), 32'd0);
        chk("rnd_model_empty", 32'(q[0].size() + q[1].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
